map_rom_arbiter: RTL and testbench

Round-robin read arbiter that lets several requesters share one read port of the map image ROM. Typical requesters are the background draw, player collision probe and enemy collision probe. It accepts address requests through a valid/grant handshake and issues at most one ROM address per cycle. Returned RGB words are tagged back to the originating requester. It sits between the game logic and one `mape_rom` read port, so several consumers can share a port without instantiating another ROM copy.

---
 rtl/map_rom_arbiter.sv | 122 ++++++++++++
 tb/tb_map_rom_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_rom_arbiter.sv
// Round-robin arbiter sharing one map ROM read port among N_REQ requesters, with tagged 3-cycle read return.
// Optional build macro MAP_ARB_PRIO0_EN gives requester 0 strict priority over the rotating requesters.
module map_rom_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 14,
   parameter int DATA_W = 12
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*ADDR_W-1:0]   addr,
   output logic [N_REQ-1:0]          gnt,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_rgb,
   output logic [N_REQ-1:0]          rd_valid,
   output logic [DATA_W-1:0]         rd_data
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [ADDR_W-1:0] addr_arr [N_REQ];

   logic [IDX_W-1:0]  last_q, last_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              s1_vld_q, s1_vld_d;
   logic [IDX_W-1:0]  s1_tag_q, s1_tag_d;
   logic              s2_vld_q, s2_vld_d;
   logic [IDX_W-1:0]  s2_tag_q, s2_tag_d;
   logic [N_REQ-1:0]  rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   logic              win_vld;
   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W-1:0]  cand_idx;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
         assign addr_arr[gi] = addr[gi*ADDR_W +: ADDR_W];
      end
   endgenerate

   // Scan from farthest to nearest so the requester closest after last_q is kept as winner.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      cand_idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand_idx = IDX_W'((int'(last_q) + k) % N_REQ);
         if (req[cand_idx]) begin
            win_vld = 1'b1;
            win_idx = cand_idx;
         end
      end
`ifdef MAP_ARB_PRIO0_EN
      if (req[0]) begin
         win_vld = 1'b1;
         win_idx = '0;
      end
`endif
   end

   always_comb begin
      gnt = '0;
      if (win_vld) begin
         gnt[win_idx] = 1'b1;
      end
   end

   always_comb begin
      last_d     = last_q;
      rom_addr_d = rom_addr_q;
      s1_vld_d   = win_vld;
      s1_tag_d   = s1_tag_q;
      s2_vld_d   = s1_vld_q;
      s2_tag_d   = s1_tag_q;
      rd_valid_d = '0;
      rd_data_d  = rd_data_q;
      if (win_vld) begin
         rom_addr_d = addr_arr[win_idx];
         s1_tag_d   = win_idx;
`ifdef MAP_ARB_PRIO0_EN
         // The priority requester stays out of the rotation.
         if (win_idx != '0) begin
            last_d = win_idx;
         end
`else
         last_d = win_idx;
`endif
      end
      if (s2_vld_q) begin
         rd_valid_d[s2_tag_q] = 1'b1;
         rd_data_d            = rom_rgb;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q     <= IDX_W'(N_REQ - 1);
         rom_addr_q <= '0;
         s1_vld_q   <= 1'b0;
         s1_tag_q   <= '0;
         s2_vld_q   <= 1'b0;
         s2_tag_q   <= '0;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else begin
         last_q     <= last_d;
         rom_addr_q <= rom_addr_d;
         s1_vld_q   <= s1_vld_d;
         s1_tag_q   <= s1_tag_d;
         s2_vld_q   <= s2_vld_d;
         s2_tag_q   <= s2_tag_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Self-checking bench for map_rom_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (circular-search arbiter and a grant queue retired three cycles later).
module tb_map_rom_arbiter;

   localparam int N  = 4;
   localparam int AW = 14;
   localparam int DW = 12;
`ifdef MAP_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*AW-1:0] addr = '0;
   logic [N-1:0]    gnt;
   logic [AW-1:0]   rom_addr;
   logic [DW-1:0]   rom_rgb;
   logic [N-1:0]    rd_valid;
   logic [DW-1:0]   rd_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   map_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .gnt(gnt),
      .rom_addr(rom_addr), .rom_rgb(rom_rgb), .rd_valid(rd_valid), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   // ROM image: rom[i] = i[11:0], one cycle read latency
   always @(posedge clk) rom_rgb <= rom_addr[DW-1:0];

   // ---------------- reference model ----------------
   typedef struct { int gcyc; int idx; logic [DW-1:0] data; } txn_t;
   txn_t         pend[$];
   int           m_last = N - 1;
   logic [N-1:0] exp_gnt = '0;
   logic [N-1:0] exp_rdv = '0;
   logic [DW-1:0] exp_rdd = '0;

   function automatic logic [N-1:0] ref_arb(input logic [N-1:0] r, input int last);
      logic [N-1:0] g;
      g = '0;
      if (PRIO0 && r[0]) begin
         g[0] = 1'b1;
         return g;
      end
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) begin
            g[(last + k) % N] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   function automatic int first_one(input logic [N-1:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return -1;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_last = N - 1;
            pend.delete();
         end
         exp_gnt = ref_arb(req, m_last);
         exp_rdv = '0;
         exp_rdd = '0;
         if (pend.size() > 0 && pend[0].gcyc + 3 == cyc) begin
            exp_rdv[pend[0].idx] = 1'b1;
            exp_rdd = pend[0].data;
         end
         @(posedge clk);
         if (rst_n) begin
            if (pend.size() > 0 && pend[0].gcyc + 3 == cyc) void'(pend.pop_front());
            if (exp_gnt != '0) begin
               int w;
               w = first_one(exp_gnt);
               if (!(PRIO0 && w == 0)) m_last = w;
               pend.push_back('{cyc, w, addr[w*AW +: DW]});
            end
         end
         cyc++;
      end
   end

   // one line per returned read
   always @(negedge clk) begin
      if (rst_n && rd_valid != '0) $display("read: cyc=%0d rd_valid=%b rd_data=%h", cyc, rd_valid, rd_data);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers (timing only) ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = '0;
      addr  = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      next_cycle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      sample();
      checks++;
      if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
      checks++;
      if (rd_valid !== '0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
      checks++;
      if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
      checks++;
      if (rom_addr !== '0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
      next_cycle();
   endtask

   task automatic test_single();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         req = (c == 0) ? 4'b0001 : 4'b0000;
         if (c == 0) addr[0 +: AW] = 14'h0123;
         sample();
         if (c == 0) begin
            checks++;
            if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
         end
         if (c == 1) begin
            checks++;
            if (rom_addr !== 14'h0123) begin failures++; $display("FAIL single_rom_addr got=%h exp=0123", rom_addr); end
         end
         checks++;
         if (rd_valid !== ((c == 3) ? 4'b0001 : 4'b0000))
            begin failures++; $display("FAIL single_rd_valid c=%0d got=%b exp=%b", c, rd_valid, (c == 3) ? 4'b0001 : 4'b0000); end
         if (c == 3) begin
            checks++;
            if (rd_data !== 12'h123) begin failures++; $display("FAIL single_rd_data got=%h exp=123", rd_data); end
         end
         next_cycle();
      end
   endtask

   task automatic test_all_four();
      logic [N-1:0] want;
      do_reset();
      for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'($urandom);
      for (int c = 0; c < 12; c++) begin
         req = (c < 8) ? 4'b1111 : 4'b0000;
         sample();
         want = '0;
         if (c < 8) want[c % 4] = 1'b1;
         checks++;
         if (gnt !== want) begin failures++; $display("FAIL all4_gnt c=%0d got=%b exp=%b", c, gnt, want); end
         want = '0;
         if (c >= 3 && c < 11) want[(c - 3) % 4] = 1'b1;
         checks++;
         if (rd_valid !== want) begin failures++; $display("FAIL all4_rd_valid c=%0d got=%b exp=%b", c, rd_valid, want); end
         if (want != '0) begin
            checks++;
            if (rd_data !== exp_rdd) begin failures++; $display("FAIL all4_rd_data c=%0d got=%h exp=%h", c, rd_data, exp_rdd); end
         end
         next_cycle();
      end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] want_d;
      for (int c = 0; c < 9; c++) begin
         req = (c < 5) ? 4'b0100 : 4'b0000;
         if (c < 5) addr[2*AW +: AW] = AW'(14'h3FFE + c);
         sample();
         checks++;
         if (gnt !== ((c < 5) ? 4'b0100 : 4'b0000))
            begin failures++; $display("FAIL wrap_gnt c=%0d got=%b exp=%b", c, gnt, (c < 5) ? 4'b0100 : 4'b0000); end
         checks++;
         if (rd_valid !== ((c >= 3 && c < 8) ? 4'b0100 : 4'b0000))
            begin failures++; $display("FAIL wrap_rd_valid c=%0d got=%b", c, rd_valid); end
         if (c >= 3 && c < 8) begin
            want_d = DW'(12'hFFE + (c - 3));
            checks++;
            if (rd_data !== want_d) begin failures++; $display("FAIL wrap_rd_data c=%0d got=%h exp=%h", c, rd_data, want_d); end
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      addr[0 +: AW]  = 14'h0111;
      addr[AW +: AW] = 14'h0222;
      for (int c = 0; c < 6; c++) begin
         req = (c < 2) ? 4'b0011 : ((c == 5) ? 4'b1111 : 4'b0000);
         if (c == 2) rst_n = 1'b0;
         sample();
         if (c == 0) begin
            checks++;
            if (gnt !== 4'b0001) begin failures++; $display("FAIL rmid_gnt0 got=%b exp=0001", gnt); end
         end
         if (c == 1) begin
            checks++;
            if (gnt !== 4'b0010) begin failures++; $display("FAIL rmid_gnt1 got=%b exp=0010", gnt); end
            checks++;
            if (rom_addr !== 14'h0111) begin failures++; $display("FAIL rmid_rom_addr1 got=%h exp=0111", rom_addr); end
         end
         if (c >= 2 && c <= 4) begin
            checks++;
            if (rd_valid !== '0) begin failures++; $display("FAIL rmid_rd_valid c=%0d got=%b exp=0", c, rd_valid); end
            checks++;
            if (rom_addr !== '0) begin failures++; $display("FAIL rmid_rom_addr c=%0d got=%h exp=0", c, rom_addr); end
         end
         if (c == 5) begin
            checks++;
            if (gnt !== 4'b0001) begin failures++; $display("FAIL rmid_post_gnt got=%b exp=0001", gnt); end
         end
         if (c == 2) #1 rst_n = 1'b1;
         next_cycle();
      end
      req = '0;
   endtask

   task automatic test_idle();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         sample();
         checks++;
         if (gnt !== '0 || rd_valid !== '0 || rom_addr !== '0)
            begin failures++; $display("FAIL idle c=%0d got gnt=%b rd_valid=%b rom_addr=%h exp=0/0/0", c, gnt, rd_valid, rom_addr); end
         next_cycle();
      end
   endtask

`ifdef MAP_ARB_PRIO0_EN
   task automatic test_prio0();
      logic [N-1:0] seq [4];
      seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0010;
      do_reset();
      for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'($urandom);
      for (int c = 0; c < 11; c++) begin
         req = (c < 4) ? 4'b1111 : ((c < 8) ? 4'b1110 : 4'b0000);
         sample();
         checks++;
         if (c < 4 && gnt !== 4'b0001) begin failures++; $display("FAIL prio_gnt c=%0d got=%b exp=0001", c, gnt); end
         else if (c >= 4 && c < 8 && gnt !== seq[c - 4]) begin failures++; $display("FAIL prio_rr c=%0d got=%b exp=%b", c, gnt, seq[c - 4]); end
         checks++;
         if (rd_valid !== exp_rdv) begin failures++; $display("FAIL prio_rd_valid c=%0d got=%b exp=%b", c, rd_valid, exp_rdv); end
         next_cycle();
      end
   endtask
`endif

   task automatic test_random();
      logic [N-1:0] prev_gnt;
      int wait_cnt [N];
      do_reset();
      prev_gnt = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 404; c++) begin
         for (int i = 0; i < N; i++) begin
            if (c >= 400) req[i] = 1'b0;
            else if (!(req[i] && !prev_gnt[i])) begin
               req[i] = ($urandom_range(0, 9) < 6);
               addr[i*AW +: AW] = AW'($urandom);
            end
         end
         sample();
         checks++;
         if (gnt !== exp_gnt) begin failures++; $display("FAIL rand_gnt c=%0d req=%b got=%b exp=%b", c, req, gnt, exp_gnt); end
         checks++;
         if (rd_valid !== exp_rdv) begin failures++; $display("FAIL rand_rd_valid c=%0d got=%b exp=%b", c, rd_valid, exp_rdv); end
         if (exp_rdv != '0) begin
            checks++;
            if (rd_data !== exp_rdd) begin failures++; $display("FAIL rand_rd_data c=%0d got=%h exp=%h", c, rd_data, exp_rdd); end
         end
         for (int i = 0; i < N; i++) begin
            wait_cnt[i] = (req[i] && !gnt[i]) ? wait_cnt[i] + 1 : 0;
            if (!PRIO0 || i == 0) begin
               checks++;
               if (wait_cnt[i] >= N) begin failures++; $display("FAIL rand_fair req=%0d got_wait=%0d exp_below=%0d", i, wait_cnt[i], N); end
            end
         end
         prev_gnt = gnt;
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_wrap();
      test_reset_mid();
      test_idle();
`ifdef MAP_ARB_PRIO0_EN
      test_prio0();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
